// File: rtl/soi_pkg.sv
// Shared types and defaults for the SOI write/override responder.
package soi_pkg;

    localparam int OP_W       = 2;
    localparam int SOI_W_DEF  = 8;
    localparam int HOLD_W_DEF = 8;

    typedef enum logic [OP_W-1:0] {
        OP_READ    = 2'b00,
        OP_SET     = 2'b01,
        OP_FORCE   = 2'b10,
        OP_RELEASE = 2'b11
    } soi_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_FORCING = 2'd2
    } resp_state_e;

endpackage

// File: rtl/soi_rsp_slot.sv
// Single-entry response register: loads on command accept, holds until the host takes it.
module soi_rsp_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_err,
    input  logic         rsp_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err
);

    // load only happens while empty, so it never collides with the consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
            rsp_err   <= load_err;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: rtl/soi_write_responder.sv
// Host get/set/force/release responder driving an override onto a signal of interest.
module soi_write_responder
    import soi_pkg::*;
#(
    parameter int SOI_W  = SOI_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [SOI_W-1:0]  cmd_data,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [SOI_W-1:0]  rsp_data,
    output logic              rsp_err,
    input  logic [SOI_W-1:0]  soi_in,
    output logic [SOI_W-1:0]  soi_out,
    output logic              forced
);

    resp_state_e       state_q, state_d;
    logic [SOI_W-1:0]  ovr_q, ovr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [SOI_W-1:0]  ld_data;
    logic              ld_err;
    logic              accept;
    soi_op_e           op;

    assign op        = soi_op_e'(cmd_op);
    assign cmd_ready = !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign forced    = (state_q != ST_IDLE);
    assign soi_out   = forced ? ovr_q : soi_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ovr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        ld_data = '0;
        ld_err  = 1'b0;

        // cnt_q == 0 while forcing means an indefinite hold; timed holds exit at 1
        case (state_q)
            ST_PULSE: state_d = ST_IDLE;
            ST_FORCING: begin
                if (cnt_q == HOLD_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: ;
        endcase

        if (accept) begin
            case (op)
                OP_READ: ld_data = soi_in;
                OP_SET: begin
                    if (state_q == ST_IDLE) begin
                        ovr_d   = cmd_data;
                        state_d = ST_PULSE;
                        ld_data = cmd_data;
                    end else begin
                        ld_data = ovr_q;
                        ld_err  = 1'b1;
                    end
                end
                OP_FORCE: begin
                    if (state_q == ST_IDLE) begin
                        ovr_d   = cmd_data;
                        cnt_d   = cmd_hold;
                        state_d = ST_FORCING;
                        ld_data = cmd_data;
                    end else begin
                        ld_data = ovr_q;
                        ld_err  = 1'b1;
                    end
                end
                OP_RELEASE: begin
                    // overrides a coincident timed expiry; both land in IDLE
                    ld_data = soi_in;
                    if (state_q == ST_FORCING) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    soi_rsp_slot #(.W(SOI_W)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (ld_data),
        .load_err  (ld_err),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

endmodule

// File: doc/soi_write_responder.md
Name: soi_write_responder

Overview:
- Hardware-side responder for host get/set access to a signal of interest (SOI).
- Accepts READ/SET/FORCE/RELEASE commands over a valid/ready command channel.
- Drives the override onto the SOI path and returns one response per command over a valid/ready response channel.
- Sits between the host-bridge command source and the design signal it observes or overrides. It is the write/override end; the existing observation path is the read end.

Parameters:
- SOI_W, 8, width of the observed/overridden signal.
- HOLD_W, 8, width of the force-duration counter.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  responder can accept a command
- cmd_op  in  2  00 READ, 01 SET, 10 FORCE, 11 RELEASE
- cmd_data  in  SOI_W  value for SET/FORCE
- cmd_hold  in  HOLD_W  FORCE duration in cycles; 0 = until RELEASE
- rsp_valid  out  1  response present
- rsp_ready  in  1  host consumes response
- rsp_data  out  SOI_W  READ: sampled soi_in; others: value now driven on soi_out
- rsp_err  out  1  command rejected
- soi_in  in  SOI_W  native design value
- soi_out  out  SOI_W  value delivered to the design
- forced  out  1  override active

Behaviour:
- Reset (async assert, sync release): state IDLE, forced=0, rsp_valid=0, rsp_data=0, rsp_err=0, counter=0, override reg=0. soi_out follows soi_in.
- soi_out = forced ? ovr_q : soi_in. This mux is combinational; it is the only combinational path from soi_in.
- cmd_ready = !rsp_valid. A command is accepted on cmd_valid && cmd_ready. At most one outstanding response.
- Response: rsp_valid rises the cycle after accept. rsp_valid, rsp_data and rsp_err hold stable until rsp_ready; they clear in the cycle rsp_ready is seen. Back-to-back commands therefore run at one per 2 cycles minimum.
- States: IDLE, PULSE, FORCING.
- READ, any state:
  - rsp_data = soi_in sampled at the accept edge (native value, not the override).
  - rsp_err = 0. State is unchanged.
- SET from IDLE:
  - ovr_q = cmd_data, forced = 1 for exactly one cycle (state PULSE), then back to IDLE with forced = 0.
  - rsp_data = cmd_data.
- FORCE from IDLE:
  - ovr_q = cmd_data, forced = 1, counter = cmd_hold, state FORCING.
  - Override is visible on soi_out the cycle after accept.
- FORCING, timed (cmd_hold != 0):
  - Counter decrements each cycle. The override spans exactly cmd_hold cycles.
  - On reaching 0: forced = 0, state IDLE.
- FORCING, indefinite (cmd_hold == 0): counter is ignored; only RELEASE exits.
- RELEASE:
  - In FORCING: forced = 0 the cycle after accept, state IDLE, rsp_err = 0, rsp_data = soi_in.
  - In IDLE: no-op, rsp_err = 0.
- SET or FORCE while in FORCING or PULSE: ignored, rsp_err = 1, the override is unchanged.
- Timed force expiring in the same cycle a RELEASE is accepted: release wins, giving a single transition to IDLE with rsp_err = 0.
- rst_n asserted mid-force: the override drops immediately (asynchronously) and any pending response is discarded.
- Counter has no wrap; a maximum cmd_hold of 2^HOLD_W-1 gives that many cycles.

Decomposition:
- Package soi_pkg:
  - typedef soi_op_e (READ, SET, FORCE, RELEASE)
  - typedef resp_state_e (IDLE, PULSE, FORCING)
  - localparams OP_W=2, default SOI_W and HOLD_W.
- One sub-module: soi_rsp_slot, a single-entry response holding register with the valid/ready handshake.
- FSM, counter and mux stay in the top module.

Test Plan:
- Reset with soi_in=8'h3C -> soi_out=8'h3C, forced=0, rsp_valid=0, cmd_ready=1.
- READ while soi_in=8'hA5 -> rsp_valid next cycle, rsp_data=8'hA5, rsp_err=0. Holding rsp_ready=0 for 3 cycles -> response stable and cmd_ready=0 throughout.
- SET 8'h55 with soi_in=8'h00 -> soi_out=8'h55 for exactly 1 cycle then 8'h00. rsp_data=8'h55.
- FORCE 8'hFF hold=4 -> soi_out=8'hFF for exactly 4 cycles starting the cycle after accept, then follows soi_in. A SET issued mid-force -> rsp_err=1, override unchanged.
- FORCE 8'h12 hold=0, then READ with soi_in=8'h34 -> rsp_data=8'h34 while soi_out=8'h12. RELEASE -> forced=0 the next cycle. RELEASE coincident with the last cycle of a hold=2 force -> single exit, rsp_err=0.
- FORCE 8'h77 hold=0, rsp_valid pending, then deassert rst_n asynchronously between edges -> soi_out immediately equals soi_in, forced=0, rsp_valid=0.
